// File: rtl/lcd_result_writer.sv
// HD44780 result writer: power-up init, then shows an 8-bit value as
// three decimal characters at line 1, column 0 on each start request.
module lcd_result_writer #(
    parameter int INIT_WAIT_CYC = 16,
    parameter int E_PULSE_CYC   = 2,
    parameter int CMD_WAIT_CYC  = 4,
    parameter int CLR_WAIT_CYC  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] result,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data
);

    localparam logic [7:0] INIT_LAST = 8'(INIT_WAIT_CYC - 1);
    localparam logic [7:0] E_LAST    = 8'(E_PULSE_CYC - 1);
    localparam logic [7:0] CMD_LAST  = 8'(CMD_WAIT_CYC - 1);
    localparam logic [7:0] CLR_LAST  = 8'(CLR_WAIT_CYC - 1);

    typedef enum logic [2:0] {
        INIT_WAIT, INIT_SEND, IDLE, CONV, WR_SEND, FIN
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP, PH_STROBE, PH_WAIT
    } phase_t;

    state_t      state, state_n;
    phase_t      phase, phase_n;
    logic [7:0]  cnt, cnt_n;
    logic [1:0]  idx, idx_n;
    logic [7:0]  data_q, data_n;
    logic        rs_q, rs_n;
    logic [19:0] sh, sh_n;
    logic [7:0]  wait_last;
    logic [8:0]  nxt;

    // One double-dabble step on {hundreds, tens, ones, binary}.
    function automatic logic [19:0] dd_step(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
        if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
        if (t[11:8] >= 4'd5) t[11:8] = t[11:8] + 4'd3;
        return {t[18:0], 1'b0};
    endfunction

    // Returns {rs, byte} for slot i of the init or write sequence.
    function automatic logic [8:0] byte_sel(
        input logic        wr,
        input logic [1:0]  i,
        input logic [11:0] bcd
    );
        logic [8:0] b;
        b = 9'h000;
        if (!wr) begin
            unique case (i)
                2'd0:    b = {1'b0, 8'h38};
                2'd1:    b = {1'b0, 8'h0C};
                2'd2:    b = {1'b0, 8'h06};
                default: b = {1'b0, 8'h01};
            endcase
        end else begin
            unique case (i)
                2'd0: b = {1'b0, 8'h80};
                2'd1: b = (bcd[11:8] == 4'd0) ? {1'b1, 8'h20}
                                              : {1'b1, 4'h3, bcd[11:8]};
                2'd2: b = (bcd[11:4] == 8'd0) ? {1'b1, 8'h20}
                                              : {1'b1, 4'h3, bcd[7:4]};
                default: b = {1'b1, 4'h3, bcd[3:0]};
            endcase
        end
        return b;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= INIT_WAIT;
            phase  <= PH_SETUP;
            cnt    <= '0;
            idx    <= '0;
            data_q <= '0;
            rs_q   <= 1'b0;
            sh     <= '0;
        end else begin
            state  <= state_n;
            phase  <= phase_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            data_q <= data_n;
            rs_q   <= rs_n;
            sh     <= sh_n;
        end
    end

    always_comb begin
        state_n   = state;
        phase_n   = phase;
        cnt_n     = cnt;
        idx_n     = idx;
        data_n    = data_q;
        rs_n      = rs_q;
        sh_n      = sh;
        busy      = 1'b1;
        done      = 1'b0;
        lcd_e     = 1'b0;
        wait_last = CMD_LAST;
        nxt       = 9'h000;
        unique case (state)
            INIT_WAIT: begin
                if (cnt == INIT_LAST) begin
                    state_n        = INIT_SEND;
                    phase_n        = PH_SETUP;
                    cnt_n          = '0;
                    idx_n          = '0;
                    {rs_n, data_n} = byte_sel(1'b0, 2'd0, sh[19:8]);
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            INIT_SEND, WR_SEND: begin
                // Clear-display needs the longer settle time.
                if (state == INIT_SEND && idx == 2'd3) wait_last = CLR_LAST;
                nxt = byte_sel(state == WR_SEND, idx + 2'd1, sh[19:8]);
                unique case (phase)
                    PH_SETUP: begin
                        phase_n = PH_STROBE;
                        cnt_n   = '0;
                    end
                    PH_STROBE: begin
                        lcd_e = 1'b1;
                        if (cnt == E_LAST) begin
                            phase_n = PH_WAIT;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt + 8'd1;
                        end
                    end
                    PH_WAIT: begin
                        if (cnt == wait_last) begin
                            cnt_n = '0;
                            if (idx == 2'd3) begin
                                state_n = (state == INIT_SEND) ? IDLE : FIN;
                            end else begin
                                idx_n          = idx + 2'd1;
                                phase_n        = PH_SETUP;
                                {rs_n, data_n} = nxt;
                            end
                        end else begin
                            cnt_n = cnt + 8'd1;
                        end
                    end
                    default: phase_n = PH_SETUP;
                endcase
            end
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_n = CONV;
                    cnt_n   = '0;
                    sh_n    = {12'd0, result};
                end
            end
            CONV: begin
                sh_n = dd_step(sh);
                if (cnt == 8'd7) begin
                    state_n        = WR_SEND;
                    phase_n        = PH_SETUP;
                    cnt_n          = '0;
                    idx_n          = '0;
                    {rs_n, data_n} = {1'b0, 8'h80};
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            FIN: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = INIT_WAIT;
        endcase
    end

    assign lcd_data = data_q;
    assign lcd_rs   = rs_q;
    assign lcd_rw   = 1'b0;

endmodule

// File: tb/tb_lcd_result_writer.sv
// Randomized bench for lcd_result_writer against a cycle-trace model
// built from the init/write byte sequences and their timing.
module tb_lcd_result_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] result;
    logic       start;
    logic       busy, done, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data;

    lcd_result_writer dut (
        .clk(clk), .rst(rst), .result(result), .start(start),
        .busy(busy), .done(done), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_e(lcd_e), .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       e;
        logic       rs;
        logic [7:0] data;
    } obs_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    obs_t       q[$];
    logic [7:0] last_d = 8'h00;
    logic       last_rs = 1'b0;
    logic       model_on = 1'b0;
    logic       prev_idle = 1'b0;

    function automatic logic [7:0] chr(input logic [7:0] r, input int pos);
        int h, t, o;
        h = r / 100;
        t = (r / 10) % 10;
        o = r % 10;
        if (pos == 0) return (h == 0) ? 8'h20 : 8'(8'h30 + h);
        if (pos == 1) return (h == 0 && t == 0) ? 8'h20 : 8'(8'h30 + t);
        return 8'(8'h30 + o);
    endfunction

    task automatic push_byte(input logic [7:0] d, input logic rs,
                             input int wt);
        q.push_back({1'b1, 1'b0, 1'b0, rs, d});
        repeat (2) q.push_back({1'b1, 1'b0, 1'b1, rs, d});
        repeat (wt) q.push_back({1'b1, 1'b0, 1'b0, rs, d});
        last_d  = d;
        last_rs = rs;
    endtask

    task automatic push_reset();
        q.delete();
        last_d  = 8'h00;
        last_rs = 1'b0;
        repeat (16) q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        push_byte(8'h38, 1'b0, 4);
        push_byte(8'h0C, 1'b0, 4);
        push_byte(8'h06, 1'b0, 4);
        push_byte(8'h01, 1'b0, 8);
    endtask

    task automatic push_write(input logic [7:0] r);
        repeat (8) q.push_back({1'b1, 1'b0, 1'b0, last_rs, last_d});
        push_byte(8'h80, 1'b0, 4);
        for (int p = 0; p < 3; p++) push_byte(chr(r, p), 1'b1, 4);
        q.push_back({1'b0, 1'b1, 1'b0, last_rs, last_d});
    endtask

    logic       r_s, s_s;
    logic [7:0] res_s;
    obs_t       exp_o, act_o;

    always @(posedge clk) begin
        r_s   = rst;
        s_s   = start;
        res_s = result;
        #1;
        if (r_s) begin
            push_reset();
            model_on = 1'b1;
        end else if (model_on && prev_idle && s_s) begin
            push_write(res_s);
        end
        if (model_on) begin
            if (q.size() > 0) begin
                exp_o     = q.pop_front();
                prev_idle = 1'b0;
            end else begin
                exp_o     = {1'b0, 1'b0, 1'b0, last_rs, last_d};
                prev_idle = 1'b1;
            end
            act_o = {busy, done, lcd_e, lcd_rs, lcd_data};
            check("cycle_obs", 32'(act_o), 32'(exp_o));
            check("lcd_rw", 32'(lcd_rw), 32'd0);
        end
    end

    logic [8:0] wr_log[$];
    int         done_cnt = 0;
    logic       prev_e = 1'b0;

    always @(posedge clk) begin
        #1;
        if (lcd_e === 1'b1 && prev_e !== 1'b1)
            wr_log.push_back({lcd_rs, lcd_data});
        if (done === 1'b1) done_cnt++;
        prev_e = lcd_e;
    end

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < max) begin
            @(negedge clk);
            n++;
        end
        check("busy_timeout", 32'(busy), 32'd0);
    endtask

    task automatic check_write(input string name, input logic [23:0] ch);
        check({name, "_n"}, wr_log.size(), 4);
        if (wr_log.size() == 4) begin
            check({name, "_cur"}, 32'(wr_log[0]), 32'h080);
            check({name, "_h"}, 32'(wr_log[1]), {23'd0, 1'b1, ch[23:16]});
            check({name, "_t"}, 32'(wr_log[2]), {23'd0, 1'b1, ch[15:8]});
            check({name, "_o"}, 32'(wr_log[3]), {23'd0, 1'b1, ch[7:0]});
        end
    endtask

    task automatic check_init(input string name);
        logic [8:0] ie[4];
        ie = '{9'h038, 9'h00C, 9'h006, 9'h001};
        check({name, "_n"}, wr_log.size(), 4);
        if (wr_log.size() == 4)
            for (int i = 0; i < 4; i++)
                check({name, "_b"}, 32'(wr_log[i]), 32'(ie[i]));
    endtask

    task automatic do_write(input logic [7:0] r);
        wr_log.delete();
        @(negedge clk);
        result = r;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        result = 8'($urandom);
        wait_idle(100);
    endtask

    logic [7:0]  dres[5];
    logic [23:0] dchr[5];
    int          rise, d0, n;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dres = '{8'hF3, 8'h07, 8'h0A, 8'h00, 8'hFF};
        dchr = '{24'h323433, 24'h202037, 24'h203130,
                 24'h202030, 24'h323535};
        rst = 1'b1;
        start = 1'b0;
        result = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rise = 0;
        for (int k = 1; k <= 100 && rise == 0; k++) begin
            @(posedge clk);
            #1;
            if (lcd_e === 1'b1) rise = k;
        end
        check("first_e_rise", rise, 17);
        wait_idle(200);
        check_init("init");

        for (int i = 0; i < 5; i++) begin
            d0 = done_cnt;
            do_write(dres[i]);
            check_write("dir", dchr[i]);
            check("dir_done", done_cnt - d0, 1);
        end

        // Re-start while busy, and again during the done cycle.
        d0 = done_cnt;
        wr_log.delete();
        @(negedge clk);
        result = 8'hE1;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        result = 8'h55;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ign_done_seen", 32'(done), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        check_write("ign", 24'h323235);
        check("ign_done", done_cnt - d0, 1);
        check("ign_busy", 32'(busy), 32'd0);

        // Reset while the hundreds digit is being strobed.
        wr_log.delete();
        @(negedge clk);
        result = 8'h99;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(wr_log.size() >= 2 && lcd_e === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mid_e_high", 32'(lcd_e), 32'd1);
        rst = 1'b1;
        start = 1'b1;
        wr_log.delete();
        d0 = done_cnt;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check("rst_e", 32'(lcd_e), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        wait_idle(200);
        check("rst_no_done", done_cnt - d0, 0);
        check_init("reinit");

        // Start held high: back-to-back writes.
        d0 = done_cnt;
        start = 1'b1;
        repeat (300) begin
            result = 8'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle(100);
        check("cont_writes", 32'(done_cnt - d0 >= 7), 32'd1);

        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 30)) begin
                result = 8'($urandom);
                @(negedge clk);
            end
            if ($urandom_range(0, 11) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst = 1'b0;
            end
            start = 1'b1;
            repeat ($urandom_range(1, 3)) begin
                result = 8'($urandom);
                @(negedge clk);
            end
            start = 1'b0;
            repeat ($urandom_range(0, 40)) begin
                result = 8'($urandom);
                if ($urandom_range(0, 7) == 0) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        wait_idle(400);
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
